// File: rtl/mmio_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mmio_bus_arbiter: two-master round-robin, single-outstanding mmio arbiter.
// Optional lock inputs with MMIO_ARB_LOCK_EN.                       Rev 1.0
// ============================================================================
module mmio_bus_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_i_req,
  input  logic [ADDR_W-1:0]   m0_i_addr,
  input  logic [DATA_W/8-1:0] m0_i_wmask,
  input  logic [DATA_W-1:0]   m0_i_wdata,
  output logic                m0_o_gnt,
  output logic                m0_o_rvalid,
  output logic [DATA_W-1:0]   m0_o_rdata,
  input  logic                m1_i_req,
  input  logic [ADDR_W-1:0]   m1_i_addr,
  input  logic [DATA_W/8-1:0] m1_i_wmask,
  input  logic [DATA_W-1:0]   m1_i_wdata,
  output logic                m1_o_gnt,
  output logic                m1_o_rvalid,
  output logic [DATA_W-1:0]   m1_o_rdata,
`ifdef MMIO_ARB_LOCK_EN
  input  logic                m0_i_lock,
  input  logic                m1_i_lock,
`endif
  output logic [ADDR_W-1:0]   arb_o_mmio_addr,
  output logic [DATA_W/8-1:0] arb_o_mmio_wmask,
  output logic [DATA_W-1:0]   arb_o_mmio_wdata,
  input  logic [DATA_W-1:0]   arb_i_mmio_rdata,
  output logic                arb_o_busy
);

  localparam int               MASK_W  = DATA_W / 8;
  localparam int               CNT_W   = 4;
  localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                resp_ph_q, resp_ph_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rsample_q, rsample_d;
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

  logic                win;
  logic                win_req;
  logic                lock_active;
  logic [MASK_W-1:0]   win_wmask;

`ifdef MMIO_ARB_LOCK_EN
  logic locked_q, locked_d;
  logic owner_lock;

  assign owner_lock  = last_gnt_q ? m1_i_lock : m0_i_lock;
  assign lock_active = locked_q & owner_lock;

  // Lock is sampled in the rvalid cycle of the owner's access.
  always_comb begin
    locked_d = locked_q;
    if (state_q == ST_RESP && resp_ph_q) locked_d = owner_lock;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) locked_q <= 1'b0;
    else      locked_q <= locked_d;
  end
`else
  assign lock_active = 1'b0;
`endif

  always_comb begin
    win     = m1_i_req & ~m0_i_req;
    win_req = m0_i_req | m1_i_req;
    if (lock_active) begin
      win     = last_gnt_q;
      win_req = last_gnt_q ? m1_i_req : m0_i_req;
    end else if (m0_i_req && m1_i_req) begin
      win = ~last_gnt_q;
    end
  end

  assign win_wmask = win ? m1_i_wmask : m0_i_wmask;

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    resp_ph_d  = resp_ph_q;
    addr_d     = addr_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    rsample_d  = rsample_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    rdata0_d   = '0;
    rdata1_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_req) begin
          state_d    = ST_ACCESS;
          last_gnt_d = win;
          addr_d     = win ? m1_i_addr  : m0_i_addr;
          wmask_d    = win_wmask;
          wdata_d    = win ? m1_i_wdata : m0_i_wdata;
          cnt_d      = (win_wmask != '0) ? CNT_ONE : CNT_LAT;
          gnt0_d     = ~win;
          gnt1_d     = win;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = ST_RESP;
          resp_ph_d = 1'b0;
          rsample_d = (wmask_q == '0) ? arb_i_mmio_rdata : '0;
          addr_d    = '0;
          wmask_d   = '0;
          wdata_d   = '0;
        end
      end
      ST_RESP: begin
        // First RESP cycle lets the bus settle; the registered rvalid lands in the second.
        if (!resp_ph_q) begin
          resp_ph_d = 1'b1;
          rvalid0_d = ~last_gnt_q;
          rvalid1_d = last_gnt_q;
          rdata0_d  = last_gnt_q ? '0 : rsample_q;
          rdata1_d  = last_gnt_q ? rsample_q : '0;
        end else begin
          state_d   = ST_IDLE;
          resp_ph_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_gnt_q <= 1'b1;
      cnt_q      <= '0;
      resp_ph_q  <= 1'b0;
      addr_q     <= '0;
      wmask_q    <= '0;
      wdata_q    <= '0;
      rsample_q  <= '0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      resp_ph_q  <= resp_ph_d;
      addr_q     <= addr_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      rsample_q  <= rsample_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign m0_o_gnt         = gnt0_q;
  assign m1_o_gnt         = gnt1_q;
  assign m0_o_rvalid      = rvalid0_q;
  assign m1_o_rvalid      = rvalid1_q;
  assign m0_o_rdata       = rdata0_q;
  assign m1_o_rdata       = rdata1_q;
  assign arb_o_mmio_addr  = addr_q;
  assign arb_o_mmio_wmask = wmask_q;
  assign arb_o_mmio_wdata = wdata_q;
  assign arb_o_busy       = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/mmio_bus_arbiter.md
Name: mmio_bus_arbiter

Overview:
- Two-master, single-outstanding arbiter in front of the mmio block's single request port.
- Master 0 is the core data port. Master 1 is a secondary requester such as a debug/loader or DMA engine.
- Serialises accesses with round-robin fairness, sequences each access through a fixed read latency, and returns data/ack only to the granted master.
- Sits between core/secondary requester and mmio in the top level.

Parameters:
- RD_LATENCY, 1, cycles from command issue to valid mmio read data; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width = DATA_W/8.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- m0_i_req  input  1  master 0 request.
- m0_i_addr  input  ADDR_W  master 0 address.
- m0_i_wmask  input  DATA_W/8  master 0 byte write mask; 0 = read.
- m0_i_wdata  input  DATA_W  master 0 write data.
- m0_o_gnt  output  1  one-cycle pulse: master 0 command captured.
- m0_o_rvalid  output  1  one-cycle pulse: master 0 access complete.
- m0_o_rdata  output  DATA_W  master 0 read data; valid with rvalid.
- m1_i_req, m1_i_addr, m1_i_wmask, m1_i_wdata, m1_o_gnt, m1_o_rvalid, m1_o_rdata: same directions, widths and meanings for master 1.
- arb_o_mmio_addr  output  ADDR_W  address to mmio.
- arb_o_mmio_wmask  output  DATA_W/8  write mask to mmio.
- arb_o_mmio_wdata  output  DATA_W  write data to mmio.
- arb_i_mmio_rdata  input  DATA_W  read data from mmio.
- arb_o_busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; last_gnt=1 so master 0 wins the first tie.
  - All outputs 0; arb_o_mmio_wmask clears immediately, without waiting for a clock edge.
  - Any in-flight access is abandoned with no rvalid.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - No req: remain in IDLE; mmio outputs are 0.
  - Exactly one req: that master wins.
  - Both req: the master other than last_gnt wins.
  - On the clock edge: latch the winner's addr/wmask/wdata into the output registers; set last_gnt=winner; load the latency counter; go to ACCESS.
- ACCESS:
  - In the first ACCESS cycle, the winner's gnt pulses for exactly one cycle. The master may drop or change its req/command from the next cycle on.
  - Write (latched wmask != 0): mmio sees the write for exactly one cycle, then go to RESP.
  - Read: hold addr for RD_LATENCY cycles with wmask=0. Sample arb_i_mmio_rdata on the last ACCESS cycle, then go to RESP.
- RESP:
  - Winner's rvalid pulses for one cycle.
  - rdata carries the sampled data for a read, 0 for a write.
  - mmio outputs return to 0; go to IDLE.
  - The non-winner's rdata/rvalid stay 0.
- Latency, req sampled to rvalid:
  - Read: 2+RD_LATENCY cycles.
  - Write: 3 cycles.
  - Peak throughput: one access per 3+RD_LATENCY cycles (read) or 4 cycles (write), including the IDLE arbitration cycle.
- Request rules:
  - Masters hold req and command stable until gnt.
  - Dropping req before gnt withdraws the request: no access, no gnt.
  - req still high in the cycle after rvalid is treated as a new request.
- Fairness: with both masters continuously requesting, grants alternate m0, m1, m0, ...; neither master waits more than one foreign access.
- Width rules: wmask is forwarded unmodified; no address decode or alignment checks are performed in this block.

Optional Feature:
- Macro MMIO_ARB_LOCK_EN adds inputs m0_i_lock and m1_i_lock (1 bit each).
- With the macro defined: if the winner's lock is high in RESP, the next IDLE arbitration grants that same master whenever it requests, overriding round-robin. The other master is blocked until lock drops. last_gnt still updates.
- Without the macro: ports absent, pure round-robin.

Test Plan:
- m0 read addr 0x8000_0004, mmio returns 0x0000_000A, RD_LATENCY=1 -> m0_o_gnt at cycle +1; m0_o_rvalid at cycle +3 with rdata 0xA; m1 outputs stay 0.
- m0 and m1 both request reads in the same cycle from reset -> m0 granted first, m1 granted on the next IDLE; two rvalids, m0's first.
- Both masters hold req for 6 accesses -> grant sequence m0,m1,m0,m1,m0,m1; arb_o_busy low exactly one cycle between accesses.
- m1 write wmask 0xF, wdata 0x0000_0005 -> arb_o_mmio_wmask=0xF for exactly one cycle; m1_o_rvalid 3 cycles after req with rdata 0.
- Assert rst=0 mid-read while in ACCESS with RD_LATENCY=4 -> outputs 0 asynchronously, no rvalid; after release, a tie goes to m0.
- With MMIO_ARB_LOCK_EN, m1 holds lock for 3 accesses while m0 requests -> m1,m1,m1 granted, then m0 on lock release.
